// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, legality bound and FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'b0000;
    localparam logic [3:0] OP_SUB       = 4'b0001;
    localparam logic [3:0] OP_AND       = 4'b0010;
    localparam logic [3:0] OP_OR        = 4'b0011;
    localparam logic [3:0] OP_SLT       = 4'b0100;
    localparam logic [3:0] OP_LEGAL_MAX = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-facing bus of the ALU sharing arbiter: two request slots and two response slots.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    // Handshakes: a transfer on bit i happens at a rising edge where valid[i] && ready[i].
    // A requester holds valid and its payload slice steady until accepted; the arbiter
    // holds resp_valid and the response fields steady until resp_ready of the owner.
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*OPW-1:0]   req_op;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [WIDTH-1:0]   resp_result;
    logic               resp_zero;
    logic               resp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_err
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the one not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters with a synchronous clear.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic [1:0]         dbg_state
`ifdef ALU_ARB_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
`endif
);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0]     alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic [1:0]         gnt;
    logic               gnt_idx;
    logic [1:0]         req_ready_w;
    logic [1:0]         resp_valid_w;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [OPW-1:0]     sel_op;
    logic               sel_legal;

    rr_arb2 u_rr_arb2 (
        .req     (bus.req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are only offered in IDLE, so a response and a new accept never share a cycle.
    assign req_ready_w = (state_q == IDLE) ? gnt : 2'b00;
    assign accept      = |(bus.req_valid & req_ready_w);

    assign sel_a     = gnt_idx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    assign sel_b     = gnt_idx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    assign sel_op    = gnt_idx ? bus.req_op[2*OPW-1:OPW]    : bus.req_op[OPW-1:0];
    assign sel_legal = (sel_op <= OPW'(OP_LEGAL_MAX));

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        resp_valid_w = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    alu_op_d = sel_op;
                    owner_d  = gnt_idx;
                    if (sel_legal) begin
                        state_d = EXEC;
                    end else begin
                        // Illegal op never reaches the ALU result path; answer with an error.
                        state_d  = RESP;
                        result_d = '0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid_w = owner_q ? 2'b10 : 2'b01;
                if (bus.resp_ready[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OPW'(OP_ADD);
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready   = req_ready_w;
    assign bus.resp_valid  = resp_valid_w;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = err_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_op          = alu_op_q;
    assign dbg_state       = state_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Clear has priority over a coincident accept; counters stick at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (perf_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (accept) begin
            if (!gnt_idx && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
            if (gnt_idx && !(&cnt1_q))  cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model of arbitration order, latency and ALU results.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             owner;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             err;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;
    logic [1:0]       dbg_state;
`ifdef ALU_ARB_PERF_EN
    logic             perf_clr;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .dbg_state  (dbg_state)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_clr   (perf_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // External ALU the arbiter feeds.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_SLT:  alu_result = WIDTH'($signed(alu_a) < $signed(alu_b));
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // ---------------- scoreboard / model state ----------------
    int               vectors     = 0;
    int               miscompares = 0;
    txn_t             exp_q[$];
    int               acc_cyc_q[$];
    int               grant_log[$];
    int               acc_log[$];
    bit               pend_v[2];
    int               pend_dly[2];
    logic [WIDTH-1:0] pend_a[2];
    logic [WIDTH-1:0] pend_b[2];
    logic [OPW-1:0]   pend_op[2];
    bit               mdl_last;
    logic [WIDTH-1:0] mdl_a, mdl_b;
    logic [OPW-1:0]   mdl_op;
    logic [WIDTH-1:0] last_res;
    logic             last_zero, last_err;

    function automatic txn_t model_txn(input int r, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
        txn_t t;
        int   sa, sb;
        sa      = int'(a);
        sb      = int'(b);
        t.owner = r[0];
        t.a     = a;
        t.b     = b;
        t.op    = op;
        t.err   = (int'(op) > 4);
        case (int'(op))
            0:       t.res = a + b;
            1:       t.res = a - b;
            2:       t.res = a & b;
            3:       t.res = a | b;
            4:       t.res = (sa < sb) ? 1 : 0;
            default: t.res = 0;
        endcase
        t.zero = !t.err && (t.res == 0);
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        mdl_last = 1'b1;
        mdl_a    = '0;
        mdl_b    = '0;
        mdl_op   = '0;
        exp_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic set_req(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [OPW-1:0] op, input int dly);
        pend_v[r]   = 1'b1;
        pend_a[r]   = a;
        pend_b[r]   = b;
        pend_op[r]  = op;
        pend_dly[r] = dly;
    endtask

    // Runs pending requests to completion, checking grants, latency, payload and stability.
    task automatic run_engine(input string tag, input int hold, input int max_cyc);
        int         cyc;
        int         hold_left;
        int         w;
        int         lat;
        logic [1:0] vis, exp_acc, exp_rv;
        txn_t       t;
        cyc       = 0;
        hold_left = hold;
        while (1) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bus.req_valid[i]              = pend_v[i] && (cyc >= pend_dly[i]);
                bus.req_a[i*WIDTH +: WIDTH]   = pend_a[i];
                bus.req_b[i*WIDTH +: WIDTH]   = pend_b[i];
                bus.req_op[i*OPW +: OPW]      = pend_op[i];
            end
            bus.resp_ready = 2'b00;
            #1;
            vectors++;
            if (alu_a !== mdl_a || alu_b !== mdl_b || alu_op !== mdl_op) begin
                miscompares++;
                $display("FAIL %s alu_operands cyc=%0d: got a=%h b=%h op=%h, expected a=%h b=%h op=%h",
                         tag, cyc, alu_a, alu_b, alu_op, mdl_a, mdl_b, mdl_op);
            end
            vis     = bus.req_valid;
            exp_acc = 2'b00;
            if (exp_q.size() == 0 && vis != 2'b00) begin
                w       = (vis == 2'b11) ? int'(!mdl_last) : int'(vis == 2'b10);
                exp_acc = (w == 1) ? 2'b10 : 2'b01;
            end
            vectors++;
            if (bus.req_ready !== exp_acc) begin
                miscompares++;
                $display("FAIL %s req_ready cyc=%0d: got %b, expected %b", tag, cyc, bus.req_ready, exp_acc);
            end
            if ((vis & bus.req_ready) != 2'b00) begin
                grant_log.push_back(int'(bus.req_ready[1]));
                acc_log.push_back(cyc);
            end
            if (exp_acc != 2'b00) begin
                w = int'(exp_acc[1]);
                t = model_txn(w, pend_a[w], pend_b[w], pend_op[w]);
                exp_q.push_back(t);
                acc_cyc_q.push_back(cyc);
                pend_v[w] = 1'b0;
                mdl_a     = pend_a[w];
                mdl_b     = pend_b[w];
                mdl_op    = pend_op[w];
                hold_left = hold;
            end
            exp_rv = 2'b00;
            if (exp_q.size() != 0) begin
                lat = exp_q[0].err ? 1 : 2;
                if (cyc - acc_cyc_q[0] >= lat) exp_rv = exp_q[0].owner ? 2'b10 : 2'b01;
            end
            vectors++;
            if (bus.resp_valid !== exp_rv) begin
                miscompares++;
                $display("FAIL %s resp_valid cyc=%0d: got %b, expected %b", tag, cyc, bus.resp_valid, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                t = exp_q[0];
                vectors++;
                if (bus.resp_result !== t.res || bus.resp_zero !== t.zero || bus.resp_err !== t.err) begin
                    miscompares++;
                    $display("FAIL %s resp_payload cyc=%0d: got res=%h zero=%b err=%b, expected res=%h zero=%b err=%b",
                             tag, cyc, bus.resp_result, bus.resp_zero, bus.resp_err, t.res, t.zero, t.err);
                end
                if (hold_left == 0) begin
                    bus.resp_ready = exp_rv;
                    last_res       = bus.resp_result;
                    last_zero      = bus.resp_zero;
                    last_err       = bus.resp_err;
                    mdl_last       = t.owner;
                    void'(exp_q.pop_front());
                    void'(acc_cyc_q.pop_front());
                end else begin
                    hold_left--;
                    bus.resp_ready = ~exp_rv;
                end
            end
            if (!pend_v[0] && !pend_v[1] && exp_q.size() == 0) break;
            cyc++;
            if (cyc >= max_cyc) begin
                miscompares++;
                $display("FAIL %s timeout: got no completion after %0d cycles, expected completion", tag, cyc);
                exp_q.delete();
                acc_cyc_q.delete();
                pend_v[0] = 1'b0;
                pend_v[1] = 1'b0;
                break;
            end
        end
        @(negedge clk);
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00 || bus.resp_result !== '0 ||
            bus.resp_zero !== 1'b0 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_resp: got rdy=%b rv=%b res=%h z=%b e=%b, expected all zero",
                     bus.req_ready, bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err);
        end
        vectors++;
        if (alu_a !== '0 || alu_b !== '0 || alu_op !== OP_ADD || dbg_state !== 2'(IDLE)) begin
            miscompares++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h st=%0d, expected 0 0 0 %0d",
                     alu_a, alu_b, alu_op, dbg_state, IDLE);
        end
        apply_reset();
    endtask

    task automatic test_single();
        set_req(0, 32'd5, 32'd7, OP_ADD, 0);
        run_engine("single", 0, 20);
        vectors++;
        if (last_res !== 32'd12 || last_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL single_result: got %0d zero=%b, expected 12 zero=0", last_res, last_zero);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        grant_log.delete();
        acc_log.delete();
        for (int r = 0; r < 2; r++) set_req(r, 32'd3, 32'd3, OP_SUB, 0);
        run_engine("contention1", 0, 30);
        for (int r = 0; r < 2; r++) set_req(r, 32'd3, 32'd3, OP_SUB, 0);
        run_engine("contention2", 0, 30);
        vectors++;
        if (grant_log.size() != 4) begin
            miscompares++;
            $display("FAIL contention_count: got %0d grants, expected 4", grant_log.size());
        end else if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
            miscompares++;
            $display("FAIL contention_order: got %0d %0d %0d %0d, expected 0 1 0 1",
                     grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
        end
        vectors++;
        if (acc_log.size() < 2) begin
            miscompares++;
            $display("FAIL issue_interval: got %0d accepts, expected at least 2", acc_log.size());
        end else if (acc_log[1] - acc_log[0] != 3) begin
            miscompares++;
            $display("FAIL issue_interval: got %0d cycles, expected 3", acc_log[1] - acc_log[0]);
        end
        vectors++;
        if (last_res !== '0 || last_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL contention_zero: got res=%h zero=%b, expected 0 zero=1", last_res, last_zero);
        end
    endtask

    task automatic test_backpressure();
        set_req(0, 32'h1234_0000, 32'h0000_5678, OP_OR, 0);
        set_req(1, 32'd40, 32'd2, OP_ADD, 3);
        run_engine("backpressure", 5, 40);
    endtask

    task automatic test_illegal();
        set_req(1, 32'd9, 32'd9, 4'b0111, 0);
        run_engine("illegal", 0, 20);
        vectors++;
        if (last_err !== 1'b1 || last_res !== '0) begin
            miscompares++;
            $display("FAIL illegal_err: got err=%b res=%h, expected err=1 res=0", last_err, last_res);
        end
        set_req(1, 32'd9, 32'd9, OP_AND, 0);
        run_engine("after_illegal", 0, 20);
        vectors++;
        if (last_err !== 1'b0 || last_res !== 32'd9) begin
            miscompares++;
            $display("FAIL after_illegal: got err=%b res=%h, expected err=0 res=9", last_err, last_res);
        end
    endtask

    task automatic test_slt();
        set_req(0, 32'hFFFF_FFFF, 32'd1, OP_SLT, 0);
        run_engine("slt_neg", 0, 20);
        vectors++;
        if (last_res !== 32'd1) begin
            miscompares++;
            $display("FAIL slt_neg: got %h, expected 1", last_res);
        end
        set_req(0, 32'd1, 32'hFFFF_FFFF, OP_SLT, 0);
        run_engine("slt_pos", 0, 20);
        vectors++;
        if (last_res !== 32'd0) begin
            miscompares++;
            $display("FAIL slt_pos: got %h, expected 0", last_res);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [OPW-1:0]   op;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                if ($urandom_range(0, 3) != 0 || r == 1 && !pend_v[0]) begin
                    a  = $urandom();
                    op = ($urandom_range(0, 1) == 1) ? OPW'($urandom_range(0, 4)) : OPW'($urandom_range(0, 15));
                    set_req(r, a, ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom()), op,
                            $urandom_range(0, 4));
                end
            end
            run_engine("random", $urandom_range(0, 3), 60);
        end
    endtask

    task automatic test_reset_mid();
        set_req(0, 32'd100, 32'd23, OP_ADD, 0);
        run_engine("pre_reset", 0, 20);
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_a     = {32'd0, 32'd9};
        bus.req_b     = {32'd0, 32'd4};
        bus.req_op    = {4'd0, OP_ADD};
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_accept: got %b, expected 01", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        vectors++;
        if (dbg_state !== 2'(EXEC)) begin
            miscompares++;
            $display("FAIL mid_exec_state: got %0d, expected %0d", dbg_state, EXEC);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.resp_valid !== 2'b00 || bus.resp_result !== '0 || alu_a !== '0 || alu_b !== '0 ||
            alu_op !== OP_ADD || dbg_state !== 2'(IDLE) || bus.req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset_values: got rv=%b res=%h a=%h b=%h op=%h st=%0d rdy=%b, expected reset values",
                     bus.resp_valid, bus.resp_result, alu_a, alu_b, alu_op, dbg_state, bus.req_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        mdl_last = 1'b1;
        mdl_a    = '0;
        mdl_b    = '0;
        mdl_op   = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (bus.resp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_no_resp: got %b, expected 00", bus.resp_valid);
            end
        end
`ifdef ALU_ARB_PERF_EN
        vectors++;
        if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            miscompares++;
            $display("FAIL perf_reset: got %0d %0d, expected 0 0", grant_cnt0, grant_cnt1);
        end
        for (int k = 0; k < 3; k++) begin
            set_req(0, 32'(k), 32'd1, OP_ADD, 0);
            run_engine("perf_count", 0, 20);
        end
        vectors++;
        if (grant_cnt0 !== CNT_W'(3) || grant_cnt1 !== '0) begin
            miscompares++;
            $display("FAIL perf_count: got %0d %0d, expected 3 0", grant_cnt0, grant_cnt1);
        end
        perf_clr = 1'b1;
        set_req(1, 32'd1, 32'd1, OP_SUB, 0);
        run_engine("perf_clr", 0, 20);
        perf_clr = 1'b0;
        vectors++;
        if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            miscompares++;
            $display("FAIL perf_clr: got %0d %0d, expected 0 0", grant_cnt0, grant_cnt1);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 2'b00;
        pend_v[0]      = 1'b0;
        pend_v[1]      = 1'b0;
`ifdef ALU_ARB_PERF_EN
        perf_clr       = 1'b0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_slt();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (ops ADD/SUB/AND/OR/SLT, 4-bit op code) between two requesters, e.g. a main execute stage and an address/branch-compare unit.
- Round-robin arbitration with valid/ready on both the request and response sides.
- Registers the ALU operands and the ALU result; the ALU itself sits outside this block.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 4, ALU op-code width.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: arbiter accepts requester i this cycle
- req_a  in  2*WIDTH  operand A; slice i belongs to requester i
- req_b  in  2*WIDTH  operand B; slice i belongs to requester i
- req_op  in  2*OPW  op code; slice i belongs to requester i
- resp_valid  out  2  bit i: result available for requester i
- resp_ready  in  2  bit i: requester i takes the result
- resp_result  out  WIDTH  result shared by both requesters; qualified by resp_valid
- resp_zero  out  1  captured ALU zero flag
- resp_err  out  1  op code was illegal
- alu_a  out  WIDTH  registered operand A to the ALU
- alu_b  out  WIDTH  registered operand B to the ALU
- alu_op  out  OPW  registered op code to the ALU
- alu_result  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: req_ready=0, resp_valid=0, resp_result=0, resp_zero=0, resp_err=0, alu_a=0, alu_b=0, alu_op=ADD (4'b0000), state=IDLE, last=1 (requester 0 wins first).
- FSM states: IDLE, EXEC, RESP.
- Grant (combinational):
  - Both valid: requester !last wins.
  - Only one valid: that requester wins.
  - req_ready[i] = (state==IDLE) && grant==i, and at most one bit is ever set.
- IDLE:
  - On req_valid[g] && req_ready[g]: latch that requester's slices into alu_a/alu_b/alu_op and owner=g.
  - Legal op (0000-0100): go EXEC.
  - Illegal op (0101-1111): skip EXEC and go straight to RESP with resp_result=0, resp_zero=0, resp_err=1.
- EXEC (one cycle): at the edge, capture alu_result into resp_result, capture alu_zero into resp_zero, set resp_err=0, go RESP.
- RESP:
  - resp_valid[owner]=1; the other bit stays 0.
  - Hold resp_result, resp_zero and resp_err stable until resp_ready[owner].
  - On handshake: last=owner, go IDLE.
  - resp_ready on the non-owner bit is ignored.
- Latency:
  - Accept edge to resp_valid high: 2 cycles for a legal op, 1 cycle for an illegal op.
  - Minimum issue interval: 3 cycles.
- alu_a, alu_b and alu_op stay constant outside the accept edge.
- resp_result is valid only while resp_valid is high.
- Simultaneous events:
  - A requester that raises valid in RESP waits; it is never granted mid-transaction.
  - A completed response and a new request never overlap in the same cycle.
- Arithmetic: performed entirely by the external ALU. SLT is signed; the result is 1 or 0, zero-extended to WIDTH.
- Reset mid-operation: the in-flight transaction is dropped, no resp_valid is produced, and the FSM returns to IDLE. Requesters must re-issue.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- With the macro:
  - Adds output ports grant_cnt0 and grant_cnt1 (each CNT_W) and input perf_clr.
  - Counter i increments on each accept handshake of requester i and saturates at all-ones.
  - perf_clr is synchronous and zeroes both counters; if it coincides with a handshake, clear wins.
  - Both counters reset to 0.
- Without the macro: none of these ports or registers exist, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_SLT=0100.
  - OP_LEGAL_MAX=0100.
  - The FSM state enum (IDLE/EXEC/RESP).
- Sub-module rr_arb2: combinational two-way round-robin grant from req_valid and last. The FSM and datapath stay in the top module.

Test Plan:
- Single request: requester 0 sends A=5, B=7, op ADD. Required: req_ready[0]=1 in the same cycle; alu_op=0000 after the edge; resp_valid[0] 2 cycles after accept; resp_result=12; resp_zero=0.
- Contention: both valid after reset, op SUB with A=3, B=3 for each. Required order: requester 0 first (result 0, resp_zero=1), then requester 1. The next pair goes to requester 0 again because last=1.
- Response backpressure: resp_ready[0] held low for 5 cycles. Required: resp_valid[0], resp_result and the ALU operands stay stable; req_ready stays 0; requester 1 waiting is not granted until the handshake.
- Illegal op: requester 1 sends op 0111. Required: resp_valid[1] 1 cycle after accept, resp_err=1, resp_result=0. The next legal op returns resp_err=0.
- SLT signed: A=-1 (0xFFFFFFFF), B=1. Required: resp_result=1. With A and B swapped: resp_result=0.
- Reset in EXEC: assert rst_n low for 1 cycle. Required: all outputs return to their reset values immediately; no resp_valid appears. With ALU_ARB_PERF_EN: grant_cnt0 and grant_cnt1 read 0; after 3 accepts by requester 0, grant_cnt0=3.
